// File: rtl/hazard_control_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// The pipeline side (master) drives the hazard sources and consumes the latch
// controls; the controller side (slave) does the opposite.
interface hazard_control_if #(
  parameter int NLATCH = 4,
  parameter int REGW   = 5,
  parameter int CNTW   = 16
);
  // hazard sources
  logic              ihit;
  logic              dhit;
  logic              dmem_req;
  logic [REGW-1:0]   id_rs;
  logic [REGW-1:0]   id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REGW-1:0]   ex_rd;
  logic              ex_memread;
  logic              ex_regwr;
  logic              br_taken;
  logic              halt_wb;
  // pipeline controls
  logic              pc_en;
  logic [NLATCH-1:0] stall;
  logic [NLATCH-1:0] flush;
  logic              halted;
  logic [CNTW-1:0]   stall_cycles;

  modport master (
    output ihit, dhit, dmem_req, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_rd, ex_memread, ex_regwr, br_taken, halt_wb,
    input  pc_en, stall, flush, halted, stall_cycles
  );

  modport slave (
    input  ihit, dhit, dmem_req, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_rd, ex_memread, ex_regwr, br_taken, halt_wb,
    output pc_en, stall, flush, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall controller. Produces per-latch stall/flush vectors and
// the PC enable from cache handshakes, load-use detection, taken branches and
// halt, and counts stall cycles in a saturating counter.
module hazard_control_unit #(
  parameter int NLATCH     = 4,
  parameter int BR_LATCH   = 2,
  parameter int LU_BUBBLES = 1,
  parameter int REGW       = 5,
  parameter int CNTW       = 16
) (
  input logic             CLK,
  input logic             nRST,
  hazard_control_if.slave hif
);

  typedef enum logic [1:0] {RUN, MEMWAIT, LUSTALL, HALTED} state_t;

  localparam logic [REGW-1:0] ZERO_REG = '0;
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_t            state, nxt_state;
  logic [1:0]        lu_cnt, nxt_lu_cnt;
  logic [CNTW-1:0]   stall_cycles;
  logic              pc_en_c;
  logic [NLATCH-1:0] stall_c, flush_c;
  logic              load_use, mem_stall;

  // Hazard detection terms shared by the priority chain below.
  always_comb begin
    load_use  = hif.ex_memread & hif.ex_regwr & (hif.ex_rd != ZERO_REG) &
                ((hif.id_use_rs & (hif.id_rs == hif.ex_rd)) |
                 (hif.id_use_rt & (hif.id_rt == hif.ex_rd)));
    // A pending data access keeps the pipe frozen until its hit arrives.
    mem_stall = (hif.dmem_req | (state == MEMWAIT)) & ~hif.dhit;
  end

  // Prioritised output decode and next-state selection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    nxt_state  = state;
    nxt_lu_cnt = lu_cnt;
    pc_en_c    = 1'b0;
    stall_c    = '0;
    flush_c    = '0;
    if (!nRST) begin
      flush_c = '1;
    end else if (state == HALTED) begin
      stall_c = '1;
    end else if (hif.halt_wb) begin
      stall_c    = '1;
      nxt_state  = HALTED;
      nxt_lu_cnt = '0;
    end else if (mem_stall) begin
      stall_c    = '1;
      nxt_state  = MEMWAIT;
      nxt_lu_cnt = '0;
    end else if (hif.br_taken & hif.ihit) begin
      // Target is loaded; squash everything fetched past the branch.
      pc_en_c = 1'b1;
      for (int i = 0; i < NLATCH; i++) begin
        if (i < BR_LATCH) flush_c[i] = 1'b1;
      end
      nxt_state  = RUN;
      nxt_lu_cnt = '0;
    end else if ((state == LUSTALL) || load_use) begin
      // Hold the consumer in IF/ID and send a bubble into ID/EX.
      stall_c[0] = 1'b1;
      flush_c[1] = 1'b1;
      if (state == LUSTALL) begin
        nxt_lu_cnt = lu_cnt - 2'd1;
        nxt_state  = (lu_cnt == 2'd1) ? RUN : LUSTALL;
      end else if (LU_BUBBLES > 1) begin
        nxt_lu_cnt = 2'(LU_BUBBLES - 1);
        nxt_state  = LUSTALL;
      end else begin
        nxt_state = RUN;
      end
    end else if (!hif.ihit) begin
      flush_c[0] = 1'b1;
      nxt_state  = RUN;
    end else begin
      pc_en_c   = 1'b1;
      nxt_state = RUN;
    end
  end

  // State, bubble counter and saturating stall-cycle counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      lu_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      state  <= nxt_state;
      lu_cnt <= nxt_lu_cnt;
      if (!pc_en_c && (state != HALTED) && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign hif.pc_en        = pc_en_c;
  assign hif.stall        = stall_c;
  assign hif.flush        = flush_c;
  assign hif.halted       = (state == HALTED);
  assign hif.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: each cycle's expected controls are
// queued as stimulus is driven and checked at the following falling edge.
module tb_hazard_control_unit;

  localparam int CNTW = 4;

  typedef struct packed {
    logic       ihit, dhit, dmem_req, br_taken, halt_wb;
    logic       ex_memread, ex_regwr;
    logic [4:0] ex_rd, id_rs;
    logic       id_use_rs;
    logic [4:0] id_rt;
    logic       id_use_rt;
  } stim_t;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       halted;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] model_cnt;
  exp_t sb[$];

  hazard_control_if #(.NLATCH(4), .REGW(5), .CNTW(CNTW)) hif ();

  hazard_control_unit #(
    .NLATCH(4), .BR_LATCH(2), .LU_BUBBLES(2), .REGW(5), .CNTW(CNTW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hif  (hif)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic stim_t mk(input logic ih, dh, dm, br, hw, mr, rw,
                               input logic [4:0] rd, rs, input logic urs,
                               input logic [4:0] rt, input logic urt);
    stim_t s;
    s = '{ihit: ih, dhit: dh, dmem_req: dm, br_taken: br, halt_wb: hw,
          ex_memread: mr, ex_regwr: rw, ex_rd: rd, id_rs: rs, id_use_rs: urs,
          id_rt: rt, id_use_rt: urt};
    return s;
  endfunction

  function automatic outs_t ex(input logic pc, input logic [3:0] st, fl, input logic h);
    outs_t o;
    o = '{pc_en: pc, stall: st, flush: fl, halted: h};
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.o   = '{pc_en: hif.pc_en, stall: hif.stall, flush: hif.flush, halted: hif.halted};
    o.cnt = hif.stall_cycles;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    hif.ihit       = s.ihit;
    hif.dhit       = s.dhit;
    hif.dmem_req   = s.dmem_req;
    hif.br_taken   = s.br_taken;
    hif.halt_wb    = s.halt_wb;
    hif.ex_memread = s.ex_memread;
    hif.ex_regwr   = s.ex_regwr;
    hif.ex_rd      = s.ex_rd;
    hif.id_rs      = s.id_rs;
    hif.id_use_rs  = s.id_use_rs;
    hif.id_rt      = s.id_rt;
    hif.id_use_rt  = s.id_use_rt;
  endtask

  task automatic push(input outs_t o, input string tag);
    exp_t e;
    e.v.o   = o;
    e.v.cnt = model_cnt;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Cross the active edge; the counter model follows the expected controls.
  task automatic advance(input obs_t e);
    @(posedge CLK);
    if (!e.o.pc_en && !e.o.halted && model_cnt != 4'd15) model_cnt = model_cnt + 4'd1;
    #1;
  endtask

  task automatic do_reset();
    nRST      = 1'b0;
    model_cnt = '0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s[3];
    outs_t x[3];
    exp_t  e;
    obs_t  o;
    nRST      = 1'b0;
    model_cnt = '0;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0));
    #3;
    push(ex(0,4'b0000,4'b1111,0), "reset_hold");
    #1;
    e = sb.pop_front(); o = observe(); n_tests++;
    if (o !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
               o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
               e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
    end
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    s[0] = mk(1,0,0,0,0,0,0,0,0,0,0,0); x[0] = ex(1,4'b0000,4'b0000,0);
    s[1] = mk(1,0,1,0,0,0,0,0,0,0,0,0); x[1] = ex(0,4'b1111,4'b0000,0);
    s[2] = mk(1,0,1,0,0,0,0,0,0,0,0,0); x[2] = ex(0,4'b1111,4'b0000,0);
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      push(x[i], $sformatf("reset_seq[%0d]", i));
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
    // Still in MEMWAIT: assert reset away from the clock edge.
    #2;
    nRST      = 1'b0;
    model_cnt = '0;
    push(ex(0,4'b0000,4'b1111,0), "reset_mid_memwait");
    #1;
    e = sb.pop_front(); o = observe(); n_tests++;
    if (o !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
               o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
               e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
    end
    @(posedge CLK);
    #1;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0));
    nRST = 1'b1;
    push(ex(1,4'b0000,4'b0000,0), "reset_release");
    @(negedge CLK);
    e = sb.pop_front(); o = observe(); n_tests++;
    if (o !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
               o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
               e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
    end
    advance(e.v);
  endtask

  task automatic test_load_use();
    stim_t s[8];
    outs_t x[8];
    exp_t  e;
    obs_t  o;
    do_reset();
    s[0] = mk(1,0,0,0,0,1,1,5'd5,5'd5,1,5'd0,0); x[0] = ex(0,4'b0001,4'b0010,0);
    s[1] = mk(1,0,0,0,0,0,0,5'd0,5'd5,1,5'd0,0); x[1] = ex(0,4'b0001,4'b0010,0);
    s[2] = mk(1,0,0,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[2] = ex(1,4'b0000,4'b0000,0);
    s[3] = mk(1,0,0,0,0,1,1,5'd7,5'd3,0,5'd7,1); x[3] = ex(0,4'b0001,4'b0010,0);
    s[4] = mk(1,0,0,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[4] = ex(0,4'b0001,4'b0010,0);
    s[5] = mk(1,0,0,0,0,1,1,5'd0,5'd0,1,5'd0,1); x[5] = ex(1,4'b0000,4'b0000,0);
    s[6] = mk(1,0,0,0,0,1,1,5'd5,5'd6,1,5'd5,0); x[6] = ex(1,4'b0000,4'b0000,0);
    s[7] = mk(1,0,0,0,0,0,1,5'd5,5'd5,1,5'd0,0); x[7] = ex(1,4'b0000,4'b0000,0);
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      push(x[i], $sformatf("load_use[%0d]", i));
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
  endtask

  task automatic test_memwait();
    stim_t s[5];
    outs_t x[5];
    exp_t  e;
    obs_t  o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s[i] = mk(1,0,1,0,0,0,0,0,0,0,0,0); x[i] = ex(0,4'b1111,4'b0000,0);
    end
    s[3] = mk(1,1,1,0,0,0,0,0,0,0,0,0); x[3] = ex(1,4'b0000,4'b0000,0);
    s[4] = mk(1,0,0,0,0,0,0,0,0,0,0,0); x[4] = ex(1,4'b0000,4'b0000,0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      push(x[i], $sformatf("memwait[%0d]", i));
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
    n_tests++;
    if (hif.stall_cycles !== 4'd3) begin
      n_fail++;
      $display("FAIL memwait_count: got %0d want 3", hif.stall_cycles);
    end
  endtask

  task automatic test_branch();
    stim_t s[9];
    outs_t x[9];
    exp_t  e;
    obs_t  o;
    do_reset();
    s[0] = mk(1,0,0,1,0,1,1,5'd5,5'd5,1,5'd0,0); x[0] = ex(1,4'b0000,4'b0011,0);
    s[1] = mk(1,0,0,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[1] = ex(1,4'b0000,4'b0000,0);
    s[2] = mk(1,0,1,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[2] = ex(0,4'b1111,4'b0000,0);
    s[3] = mk(1,1,1,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[3] = ex(1,4'b0000,4'b0011,0);
    s[4] = mk(1,0,0,0,0,1,1,5'd9,5'd9,1,5'd0,0); x[4] = ex(0,4'b0001,4'b0010,0);
    s[5] = mk(1,0,0,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[5] = ex(1,4'b0000,4'b0011,0);
    s[6] = mk(1,0,0,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[6] = ex(1,4'b0000,4'b0000,0);
    s[7] = mk(0,0,0,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[7] = ex(0,4'b0000,4'b0001,0);
    s[8] = mk(1,0,0,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[8] = ex(1,4'b0000,4'b0000,0);
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      push(x[i], $sformatf("branch[%0d]", i));
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
  endtask

  task automatic test_halt();
    stim_t s[6];
    outs_t x[6];
    exp_t  e;
    obs_t  o;
    do_reset();
    s[0] = mk(1,0,0,0,1,0,0,5'd0,5'd0,0,5'd0,0); x[0] = ex(0,4'b1111,4'b0000,0);
    s[1] = mk(0,0,0,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[1] = ex(0,4'b1111,4'b0000,1);
    s[2] = mk(1,0,0,1,0,0,0,5'd0,5'd0,0,5'd0,0); x[2] = ex(0,4'b1111,4'b0000,1);
    s[3] = mk(1,0,1,0,0,0,0,5'd0,5'd0,0,5'd0,0); x[3] = ex(0,4'b1111,4'b0000,1);
    s[4] = mk(0,1,0,0,0,1,1,5'd4,5'd4,1,5'd0,0); x[4] = ex(0,4'b1111,4'b0000,1);
    s[5] = mk(1,0,0,0,1,0,0,5'd0,5'd0,0,5'd0,0); x[5] = ex(0,4'b1111,4'b0000,1);
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      push(x[i], $sformatf("halt[%0d]", i));
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    obs_t o;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i < 20) begin
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        push(ex(0,4'b0000,4'b0001,0), $sformatf("saturate[%0d]", i));
      end else begin
        drive(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        push(ex(1,4'b0000,4'b0000,0), $sformatf("saturate[%0d]", i));
      end
      @(negedge CLK);
      e = sb.pop_front(); o = observe(); n_tests++;
      if (o !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b/%b/%b/%b cnt=%0d want %b/%b/%b/%b cnt=%0d", e.tag,
                 o.o.pc_en, o.o.stall, o.o.flush, o.o.halted, o.cnt,
                 e.v.o.pc_en, e.v.o.stall, e.v.o.flush, e.v.o.halted, e.v.cnt);
      end
      advance(e.v);
    end
    n_tests++;
    if (hif.stall_cycles !== 4'd15) begin
      n_fail++;
      $display("FAIL saturate_final: got %0d want 15", hif.stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_memwait();
    test_branch();
    test_halt();
    test_saturate();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
